// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch/stall front end.
package fetch_pkg;

  localparam int unsigned CTRL_W = 9;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_RUN   = 2'b00,
    FETCH_STALL = 2'b01,
    FETCH_FLUSH = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a NOP bubble, hold keeps contents, else captures fetch.
module if_id_reg #(
  parameter int unsigned          PC_W      = 32,
  parameter int unsigned          INSTR_W   = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  input  logic               i_hold,
  input  logic [PC_W-1:0]    i_pc4,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [PC_W-1:0]    o_pc4,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
);

  logic [PC_W-1:0]    r_pc4;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;

  // Flush beats hold so a redirect always empties the slot.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_pc4   <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (!i_hold) begin
      r_pc4   <= i_pc4;
      r_instr <= i_instr;
      r_valid <= 1'b1;
    end
  end

  assign o_pc4   = r_pc4;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stall_unit.sv
// Front end: PC, IF/ID and ID/EX control under hold/bubble/redirect control with stall watchdog.
// FETCH_PERF_CNT_EN adds free-running stall_cycles and flush_count outputs.
module fetch_stall_unit #(
  parameter int unsigned        PC_W      = 32,
  parameter int unsigned        INSTR_W   = 32,
  parameter int unsigned        CTRL_W    = fetch_pkg::CTRL_W,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR,
  parameter int unsigned        MAX_STALL = 15
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_hold_pc,
  input  logic               i_hold_if_id,
  input  logic               i_mux_selector,
  input  logic               i_branch_resolved,
  input  logic               i_branch_taken,
  input  logic [PC_W-1:0]    i_branch_target,
  input  logic [INSTR_W-1:0] i_imem_instr,
  input  logic [CTRL_W-1:0]  i_id_ctrl,
  output logic [PC_W-1:0]    o_pc,
  output logic [PC_W-1:0]    o_if_id_pc4,
  output logic [INSTR_W-1:0] o_if_id_instr,
  output logic               o_if_id_valid,
  output logic [CTRL_W-1:0]  o_id_ex_ctrl,
  output logic [1:0]         o_fetch_state,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]        o_stall_cycles,
  output logic [31:0]        o_flush_count,
`endif
  output logic               o_stall_err
);

  import fetch_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);

  logic [PC_W-1:0]   r_pc, w_pc_d, w_pc_inc;
  logic [CTRL_W-1:0] r_id_ex_ctrl, w_id_ex_ctrl_d;
  fetch_state_t      r_state, w_state_d;
  logic [CNT_W-1:0]  r_stall_cnt, w_stall_cnt_d;
  logic              r_stall_err;
  logic              w_redirect, w_hold_any;

  always_comb begin
    w_redirect = i_branch_resolved & i_branch_taken;
    w_hold_any = i_hold_pc | i_hold_if_id;
    w_pc_inc   = r_pc + PC_W'(4);

    if (w_redirect)      w_pc_d = i_branch_target;
    else if (i_hold_pc)  w_pc_d = r_pc;
    else                 w_pc_d = w_pc_inc;

    w_id_ex_ctrl_d = (w_redirect || i_mux_selector) ? '0 : i_id_ctrl;

    if (w_redirect)      w_state_d = FETCH_FLUSH;
    else if (w_hold_any) w_state_d = FETCH_STALL;
    else                 w_state_d = FETCH_RUN;

    // Counter tracks the stall cycle being entered, so the Nth held edge reads N.
    w_stall_cnt_d = '0;
    if (w_state_d == FETCH_STALL) begin
      w_stall_cnt_d = (r_stall_cnt == CNT_W'(MAX_STALL)) ? r_stall_cnt : r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pc         <= RESET_PC;
      r_id_ex_ctrl <= '0;
      r_state      <= FETCH_RUN;
      r_stall_cnt  <= '0;
      r_stall_err  <= 1'b0;
    end else begin
      r_pc         <= w_pc_d;
      r_id_ex_ctrl <= w_id_ex_ctrl_d;
      r_state      <= w_state_d;
      r_stall_cnt  <= w_stall_cnt_d;
      r_stall_err  <= r_stall_err | (w_stall_cnt_d == CNT_W'(MAX_STALL));
    end
  end

  if_id_reg #(
    .PC_W      (PC_W),
    .INSTR_W   (INSTR_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (w_redirect),
    .i_hold  (i_hold_if_id),
    .i_pc4   (w_pc_inc),
    .i_instr (i_imem_instr),
    .o_pc4   (o_if_id_pc4),
    .o_instr (o_if_id_instr),
    .o_valid (o_if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cycles, r_flush_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_stall_cycles <= r_stall_cycles + 32'(i_hold_pc);
      r_flush_count  <= r_flush_count + 32'(w_redirect);
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_count  = r_flush_count;
`endif

  assign o_pc          = r_pc;
  assign o_id_ex_ctrl  = r_id_ex_ctrl;
  assign o_fetch_state = r_state;
  assign o_stall_err   = r_stall_err;

endmodule

// File: tb/tb_fetch_stall_unit.sv
// Directed scoreboard bench: stimulus queues expected post-edge state, monitor compares.
module tb_fetch_stall_unit;

  logic        clk = 1'b0;
  logic        rst_n, hold_pc, hold_if_id, mux_sel, br_res, br_tk;
  logic [31:0] br_tgt, imem;
  logic [8:0]  id_ctrl;
  logic [31:0] pc, if_id_pc4, if_id_instr;
  logic        if_id_valid, stall_err;
  logic [8:0]  id_ex_ctrl;
  logic [1:0]  fstate;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  localparam logic [1:0] RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10;

  typedef struct {
    string       name;
    logic [31:0] pc, pc4, instr;
    logic        valid;
    logic [8:0]  ctrl;
    logic [1:0]  st;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t e_cur;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stall_unit dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_hold_pc         (hold_pc),
    .i_hold_if_id      (hold_if_id),
    .i_mux_selector    (mux_sel),
    .i_branch_resolved (br_res),
    .i_branch_taken    (br_tk),
    .i_branch_target   (br_tgt),
    .i_imem_instr      (imem),
    .i_id_ctrl         (id_ctrl),
    .o_pc              (pc),
    .o_if_id_pc4       (if_id_pc4),
    .o_if_id_instr     (if_id_instr),
    .o_if_id_valid     (if_id_valid),
    .o_id_ex_ctrl      (id_ex_ctrl),
    .o_fetch_state     (fstate),
`ifdef FETCH_PERF_CNT_EN
    .o_stall_cycles    (stall_cycles),
    .o_flush_count     (flush_count),
`endif
    .o_stall_err       (stall_err)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: every edge that has a queued expectation is checked 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "pc",    pc,                  e.pc);
        chk(e.name, "pc4",   if_id_pc4,           e.pc4);
        chk(e.name, "instr", if_id_instr,         e.instr);
        chk(e.name, "valid", 32'(if_id_valid),    32'(e.valid));
        chk(e.name, "ctrl",  32'(id_ex_ctrl),     32'(e.ctrl));
        chk(e.name, "state", 32'(fstate),         32'(e.st));
        chk(e.name, "err",   32'(stall_err),      32'(e.err));
      end
    end
  end

  task automatic drv(input logic rn, input logic hp, input logic hi, input logic mx,
                     input logic br, input logic bt, input logic [31:0] tgt,
                     input logic [31:0] im, input logic [8:0] ct);
    rst_n = rn; hold_pc = hp; hold_if_id = hi; mux_sel = mx;
    br_res = br; br_tk = bt; br_tgt = tgt; imem = im; id_ctrl = ct;
  endtask

  task automatic expect_edge(input string nm, input logic [31:0] p, input logic [31:0] p4,
                             input logic [31:0] ins, input logic v, input logic [8:0] c,
                             input logic [1:0] s, input logic er);
    e_cur.name = nm; e_cur.pc = p; e_cur.pc4 = p4; e_cur.instr = ins;
    e_cur.valid = v; e_cur.ctrl = c; e_cur.st = s; e_cur.err = er;
    @(posedge clk);
    q.push_back(e_cur);
    @(negedge clk);
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 32'h0, 32'h1111_1111, 9'h155);
    @(negedge clk);
    expect_edge("reset", 0, 0, 0, 0, 0, RUN, 0);

    // Free run after reset
    drv(1, 0, 0, 0, 0, 0, 32'h0, 32'h1111_1111, 9'h155);
    expect_edge("run1", 32'h4, 32'h4, 32'h1111_1111, 1, 9'h155, RUN, 0);
    imem = 32'h2222_2222;
    expect_edge("run2", 32'h8, 32'h8, 32'h2222_2222, 1, 9'h155, RUN, 0);
    imem = 32'h3333_3333;
    expect_edge("run3", 32'hC, 32'hC, 32'h3333_3333, 1, 9'h155, RUN, 0);
    imem = 32'h4444_4444;
    expect_edge("run4", 32'h10, 32'h10, 32'h4444_4444, 1, 9'h155, RUN, 0);

    // Load-use bubble
    drv(1, 1, 1, 1, 0, 0, 32'h0, 32'h5555_5555, 9'h0AA);
    expect_edge("loaduse", 32'h10, 32'h10, 32'h4444_4444, 1, 9'h000, STALL, 0);
    drv(1, 0, 0, 0, 0, 0, 32'h0, 32'h5555_5555, 9'h0AA);
    expect_edge("loaduse_rel", 32'h14, 32'h14, 32'h5555_5555, 1, 9'h0AA, RUN, 0);

    // Redirect wins over holds
    drv(1, 1, 1, 0, 1, 1, 32'h80, 32'h5555_5555, 9'h0AA);
    expect_edge("redirect", 32'h80, 32'h0, 32'h0, 0, 9'h000, FLUSH, 0);
    drv(1, 0, 0, 0, 0, 0, 32'h0, 32'h6666_6666, 9'h0AA);
    expect_edge("post_flush", 32'h84, 32'h84, 32'h6666_6666, 1, 9'h0AA, RUN, 0);

    // Not-taken branch has no effect
    drv(1, 0, 0, 0, 1, 0, 32'h200, 32'h7777_7777, 9'h0AA);
    expect_edge("not_taken", 32'h88, 32'h88, 32'h7777_7777, 1, 9'h0AA, RUN, 0);

    // Independent holds
    drv(1, 1, 0, 0, 0, 0, 32'h0, 32'h8888_8888, 9'h0AA);
    expect_edge("hold_pc_only", 32'h88, 32'h8C, 32'h8888_8888, 1, 9'h0AA, STALL, 0);
    drv(1, 0, 1, 0, 0, 0, 32'h0, 32'h9999_9999, 9'h0AA);
    expect_edge("hold_ifid_only", 32'h8C, 32'h8C, 32'h8888_8888, 1, 9'h0AA, STALL, 0);
    drv(1, 0, 0, 0, 0, 0, 32'h0, 32'hAAAA_AAAA, 9'h0AA);
    expect_edge("hold_rel", 32'h90, 32'h90, 32'hAAAA_AAAA, 1, 9'h0AA, RUN, 0);

    // Watchdog: error exactly on the 15th held edge, sticky afterwards
    drv(1, 1, 1, 0, 0, 0, 32'h0, 32'hAAAA_AAAA, 9'h0AA);
    for (int i = 1; i <= 15; i++)
      expect_edge($sformatf("wdog%0d", i), 32'h90, 32'h90, 32'hAAAA_AAAA, 1, 9'h0AA, STALL,
                  (i == 15));
    hold_pc = 0; hold_if_id = 0;
    expect_edge("wdog_drop1", 32'h94, 32'h94, 32'hAAAA_AAAA, 1, 9'h0AA, RUN, 1);
    expect_edge("wdog_drop2", 32'h98, 32'h98, 32'hAAAA_AAAA, 1, 9'h0AA, RUN, 1);
    rst_n = 0;
    expect_edge("wdog_reset", 0, 0, 0, 0, 0, RUN, 0);

    // Reset mid-stall with counter at 7; counter must restart from zero
    drv(1, 1, 1, 0, 0, 0, 32'h0, 32'hAAAA_AAAA, 9'h0AA);
    for (int i = 1; i <= 7; i++)
      expect_edge($sformatf("mid%0d", i), 0, 0, 0, 0, 9'h0AA, STALL, 0);
    rst_n = 0;
    expect_edge("mid_reset", 0, 0, 0, 0, 0, RUN, 0);
    rst_n = 1;
    for (int i = 1; i <= 15; i++)
      expect_edge($sformatf("recount%0d", i), 0, 0, 0, 0, 9'h0AA, STALL, (i == 15));

    // PC wrap
    drv(1, 0, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'hAAAA_AAAA, 9'h0AA);
    expect_edge("to_top", 32'hFFFF_FFFC, 0, 0, 0, 0, FLUSH, 1);
    drv(1, 0, 0, 0, 0, 0, 32'h0, 32'hBBBB_BBBB, 9'h0AA);
    expect_edge("wrap", 32'h0, 32'h0, 32'hBBBB_BBBB, 1, 9'h0AA, RUN, 1);

    // FLUSH -> STALL
    drv(1, 0, 0, 0, 1, 1, 32'h40, 32'hBBBB_BBBB, 9'h0AA);
    expect_edge("flush2", 32'h40, 0, 0, 0, 0, FLUSH, 1);
    drv(1, 1, 1, 0, 0, 0, 32'h0, 32'hCCCC_CCCC, 9'h0AA);
    expect_edge("flush_to_stall", 32'h40, 0, 0, 0, 9'h0AA, STALL, 1);

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
